seq_mult_32bit: RTL and testbench

Multi-cycle 32x32 -> 64-bit integer multiplier for the KGP-RISC execute stage, built as a shift-add engine around one 32-bit carry-lookahead adder. Each cycle the engine drives the adder's operands and carry-in, then consumes its sum and carry-out. It handles signed and unsigned multiplies through a start/done handshake. The full 64-bit product is held until the next operation is accepted.

---
 rtl/seq_mult_32bit.sv | 178 +++++++++++++++++
 tb/tb_seq_mult_32bit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_32bit.sv
// seq_mult_32bit: 32x32 -> 64-bit signed/unsigned shift-add multiplier built around one 32-bit CLA.
// Optional macro SEQ_MULT_ZERO_SKIP_EN: a zero operand skips RUN/FIX and finishes two cycles after start.

module seq_mult_cla32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Full lookahead inside each 4-bit group; group carry-outs feed the next group
  always_comb begin
    c    = '0;
    c[0] = c_in;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum   = p ^ c[31:0];
  assign c_out = c[32];
endmodule

module seq_mult_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod_hi,
  output logic [31:0] prod_lo
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sgn_r;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc_hi;
  logic        neg;
  logic [4:0]  count;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] cla_x;
  logic [31:0] cla_y;
  logic        cla_cin;
  logic [31:0] cla_sum;
  logic        cla_cout;

  // -2^31 negates to itself, which is exactly its magnitude read as unsigned
  assign a_abs = (sgn_r && a_r[31]) ? (~a_r + 32'd1) : a_r;
  assign b_abs = (sgn_r && b_r[31]) ? (~b_r + 32'd1) : b_r;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (a_r == 32'd0) || (b_r == 32'd0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = PREP;
`ifdef SEQ_MULT_ZERO_SKIP_EN
      PREP: state_next = zero_op ? DONE : RUN;
`else
      PREP: state_next = RUN;
`endif
      RUN:  if (count == 5'd31) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FIX reuses the adder for the low word of the 64-bit negate (~lo + 1)
  always_comb begin
    cla_x   = acc_hi;
    cla_y   = mplier[0] ? mcand : 32'd0;
    cla_cin = 1'b0;
    if (state == FIX) begin
      cla_x   = ~mplier;
      cla_y   = 32'd0;
      cla_cin = 1'b1;
    end
  end

  seq_mult_cla32 u_cla (
    .x     (cla_x),
    .y     (cla_y),
    .c_in  (cla_cin),
    .sum   (cla_sum),
    .c_out (cla_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sgn_r   <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      neg     <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else begin
      done <= 1'b0;
      // busy stays up through the cycle in which done is shown
      busy <= (state_next != IDLE) || (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            sgn_r <= sgn;
          end
        end
        PREP: begin
          mcand  <= a_abs;
          mplier <= b_abs;
          neg    <= sgn_r & (a_r[31] ^ b_r[31]);
          acc_hi <= '0;
          count  <= '0;
`ifdef SEQ_MULT_ZERO_SKIP_EN
          if (zero_op) begin
            mplier <= '0;
            neg    <= 1'b0;
          end
`endif
        end
        RUN: begin
          acc_hi <= {cla_cout, cla_sum[31:1]};
          mplier <= {cla_sum[0], mplier[31:1]};
          count  <= count + 5'd1;
        end
        FIX: begin
          if (neg) begin
            mplier <= cla_sum;
            acc_hi <= ~acc_hi + {31'd0, cla_cout};
          end
        end
        DONE: begin
          done    <= 1'b1;
          prod_hi <= acc_hi;
          prod_lo <= mplier;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_32bit.sv
// tb_seq_mult_32bit: self-checking bench for seq_mult_32bit against a plain-arithmetic product model.
// Honours SEQ_MULT_ZERO_SKIP_EN when computing expected latency.

module tb_seq_mult_32bit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;

  int checks = 0;
  int failures = 0;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  seq_mult_32bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sgn     (sgn),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mult(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic [63:0]        ux;
    logic [63:0]        uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (s) return sx * sy;
    return ux * uy;
  endfunction

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
    return (ZERO_SKIP && (x == 32'd0 || y == 32'd0)) ? 2 : 35;
  endfunction

  // Present one request for a single clock, then scramble the inputs
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; sgn = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sgn = ($urandom_range(0, 1) == 1);
  endtask

  task automatic wait_done(output int lat, output int busy_lows, output logic [63:0] p,
                           output logic done_after, output logic busy_after);
    logic found;
    found = 1'b0; lat = -1; busy_lows = 0; p = '0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_lows++;
      if (done === 1'b1) begin
        found = 1'b1; lat = k; p = {prod_hi, prod_lo};
      end
    end
    @(negedge clk);
    done_after = done; busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 32'h1234_5678; b = 32'h9abc_def0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if ({prod_hi, prod_lo} !== 64'd0) begin failures++; $display("[TB] FAIL reset_prod: got %h expected 0", {prod_hi, prod_lo}); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_vectors();
    logic [64:0] vecs [8];
    logic        s;
    logic [31:0] x, y;
    logic [63:0] p;
    int          lat, lows;
    logic        d_after, b_after;
    vecs = '{ {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF}, {1'b1, 32'hFFFFFFFD, 32'h00000007},
              {1'b0, 32'hFFFFFFFD, 32'h00000007}, {1'b1, 32'h80000000, 32'h80000000},
              {1'b1, 32'h80000000, 32'h00000001}, {1'b0, 32'h00000000, 32'hDEADBEEF},
              {1'b1, 32'hDEADBEEF, 32'h00000000}, {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF} };
    for (int i = 0; i < 8; i++) begin
      s = vecs[i][64]; x = vecs[i][63:32]; y = vecs[i][31:0];
      issue(s, x, y);
      wait_done(lat, lows, p, d_after, b_after);
      checks++; if (p !== ref_mult(s, x, y)) begin failures++; $display("[TB] FAIL vec%0d_prod: got %h expected %h", i, p, ref_mult(s, x, y)); end
      checks++; if (lat !== exp_lat(x, y)) begin failures++; $display("[TB] FAIL vec%0d_latency: got %0d expected %0d", i, lat, exp_lat(x, y)); end
      checks++; if (lows !== 0) begin failures++; $display("[TB] FAIL vec%0d_busy_held: got %0d low cycles expected 0", i, lows); end
      checks++; if (d_after !== 1'b0) begin failures++; $display("[TB] FAIL vec%0d_done_pulse: got %b expected 0", i, d_after); end
      checks++; if (b_after !== 1'b0) begin failures++; $display("[TB] FAIL vec%0d_busy_release: got %b expected 0", i, b_after); end
    end
  endtask

  task automatic test_random();
    logic        s;
    logic [31:0] x, y;
    logic [63:0] p;
    int          lat, lows;
    logic        d_after, b_after;
    for (int i = 0; i < 24; i++) begin
      s = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0: x = 32'h0;
        1: x = 32'h80000000;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: y = 32'hFFFFFFFF;
        1: y = 32'h1;
        default: y = $urandom;
      endcase
      issue(s, x, y);
      wait_done(lat, lows, p, d_after, b_after);
      checks++; if (p !== ref_mult(s, x, y)) begin failures++; $display("[TB] FAIL rand%0d_prod: s=%b a=%h b=%h got %h expected %h", i, s, x, y, p, ref_mult(s, x, y)); end
      checks++; if (lat !== exp_lat(x, y)) begin failures++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, lat, exp_lat(x, y)); end
    end
  endtask

  task automatic test_handshake();
    logic [63:0] prev, got1, got2, exp1, exp2;
    logic [31:0] x1, y1, x2, y2;
    int          lat, lows, lat1, lat2, viol1, viol2;
    logic        d_after, b_after, found;
    issue(1'b0, 32'd3, 32'd5);
    wait_done(lat, lows, prev, d_after, b_after);
    checks++; if (prev !== 64'd15) begin failures++; $display("[TB] FAIL hs_setup_prod: got %h expected %h", prev, 64'd15); end
    x1 = $urandom | 32'h1; y1 = $urandom | 32'h100; exp1 = ref_mult(1'b1, x1, y1);
    x2 = $urandom | 32'h4; y2 = $urandom | 32'h2; exp2 = ref_mult(1'b0, x2, y2);
    @(posedge clk); #1;
    start = 1'b1; sgn = 1'b1; a = x1; b = y1;
    @(posedge clk); #1;
    found = 1'b0; lat1 = -1; viol1 = 0; got1 = '0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1; lat1 = k; got1 = {prod_hi, prod_lo};
        sgn = 1'b0; a = x2; b = y2;
      end else begin
        if ({prod_hi, prod_lo} !== prev) viol1++;
        a = $urandom; b = $urandom;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    found = 1'b0; lat2 = -1; viol2 = 0; got2 = '0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1; lat2 = k; got2 = {prod_hi, prod_lo};
      end else if ({prod_hi, prod_lo} !== got1) viol2++;
    end
    checks++; if (got1 !== exp1) begin failures++; $display("[TB] FAIL hs_first_prod: got %h expected %h", got1, exp1); end
    checks++; if (lat1 !== 35) begin failures++; $display("[TB] FAIL hs_first_latency: got %0d expected 35", lat1); end
    checks++; if (viol1 !== 0) begin failures++; $display("[TB] FAIL hs_prev_hold: got %0d changes expected 0", viol1); end
    checks++; if (got2 !== exp2) begin failures++; $display("[TB] FAIL hs_second_prod: got %h expected %h", got2, exp2); end
    checks++; if (lat2 !== 35) begin failures++; $display("[TB] FAIL hs_second_latency: got %0d expected 35", lat2); end
    checks++; if (viol2 !== 0) begin failures++; $display("[TB] FAIL hs_first_hold: got %0d changes expected 0", viol2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] p;
    int          lat, lows;
    logic        d_after, b_after;
    @(posedge clk); #1;
    start = 1'b1; sgn = 1'b1; a = 32'hC000_0123; b = 32'h0777_1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1; sgn = 1'b0; a = 32'd12345; b = 32'd678;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    checks++; if ({prod_hi, prod_lo} !== 64'd0) begin failures++; $display("[TB] FAIL midrst_prod: got %h expected 0", {prod_hi, prod_lo}); end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, lows, p, d_after, b_after);
    checks++; if (p !== ref_mult(1'b0, 32'd12345, 32'd678)) begin failures++; $display("[TB] FAIL midrst_next_prod: got %h expected %h", p, ref_mult(1'b0, 32'd12345, 32'd678)); end
    checks++; if (lat !== 35) begin failures++; $display("[TB] FAIL midrst_next_latency: got %0d expected 35", lat); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_handshake();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
